fp_add_control: RTL and testbench
=================================

Name: fp_add_control

Overview:
Control FSM sitting directly upstream of the floating-point add datapath; it generates every mux select, ALU opcode, shift amount and load enable that datapath consumes.
- Sequences exponent compare, mantissa alignment, mantissa add, normalisation and rounding.
- Re-runs normalisation when the rounder flags a non-normalised result.
- Provides a start/busy/done handshake to the core and tracks the result exponent for overflow/underflow flags.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)
MAX_RENORM, 2, max normalise/round re-passes after the first

Ports:
clk  in  1  system clock
reset  in  1  reset
start  in  1  begin operation; sampled only in IDLE
exp_a  in  EXP_W  exponent field, operand A
exp_b  in  EXP_W  exponent field, operand B
big_sum  in  MAN_W+2  mantissa sum incl. carry (bit MAN_W+1)
not_normalized  in  1  rounder output still not normalised
busy  out  1  high from EXP_CMP through DONE
done  out  1  one-cycle pulse in DONE
sel_small  out  1  1: B has smaller exponent (shifted); 0: A
sel_large  out  1  always ~sel_small
sel_exp_src  out  1  0: input exponent; 1: fed-back result exponent
sel_mant_src  out  1  0: big ALU sum; 1: rounder feedback
sel_exp_out  out  1  0: inc/dec unit; 1: small-ALU register
shift_right_amt  out  8  alignment shift
shift_norm_amt  out  6  signed; +left, -right
small_alu_op  out  4  small ALU opcode
big_alu_op  out  4  big ALU opcode
incdec_op  out  4  inc/dec opcode
incdec_en  out  1  inc/dec enable
load_final  out  1  final register load
overflow  out  1  sticky until next start
underflow  out  1  sticky until next start

Behaviour:
- Reset:
  - One clock, `clk`. Reset is asynchronous and active-high, port `reset`.
  - All outputs 0, state IDLE, internal exponent and renorm counter 0.
  - Reset asserted mid-operation aborts immediately. No done pulse.
- States: IDLE -> EXP_CMP -> ALIGN -> ADD -> NORM -> ROUND -> CHECK -> DONE -> IDLE.
  - One cycle each except IDLE.
  - `start` high in IDLE moves to EXP_CMP next edge and clears the flags.
  - `start` is ignored while busy.
- EXP_CMP:
  - small_alu_op=SUB.
  - Register diff=|exp_a-exp_b| and e_res=max(exp_a, exp_b).
  - sel_small=1 when exp_b<=exp_a. On a tie, B is shifted by 0.
- ALIGN: shift_right_amt=min(diff, MAN_W+2). Any diff>=25 forces 25, so the shifted operand is zero.
- ADD: big_alu_op=ADD, held one cycle.
- NORM, driven by big_sum (or the fed-back mantissa on re-pass):
  - Bit MAN_W+1 set: shift_norm_amt=-1, incdec_op=INC, incdec_en=1, e_res+1.
  - Otherwise, with p the leading-one position: shift_norm_amt=MAN_W-p, incdec_op=DEC by that count, e_res reduced by the same count.
  - Sum zero: e_res=0, skip to DONE with load_final=1.
- ROUND: load_final=1. sel_exp_out=0, except when no adjustment occurred, in which case sel_exp_out=1.
- CHECK:
  - not_normalized=1 and renorm count < MAX_RENORM: count+1, then NORM with sel_mant_src=1, sel_exp_src=1.
  - Otherwise go to DONE.
- Latency:
  - Without re-pass, start sampled at cycle 0 gives done at cycle 7.
  - Each re-pass adds 3 cycles.
- Exponent boundaries:
  - e_res+1 >= 2^EXP_W-1: overflow=1, e_res saturates to 2^EXP_W-2.
  - Decrement below 1: underflow=1, result flushed to zero (e_res=0).
- Opcodes are held 0 (NOP) in every state not listed above.

Optional Feature:
FP_CTRL_SUB_EN
- With the macro:
  - Adds inputs sign_a, sign_b and output result_sign.
  - Unequal signs select big_alu_op=SUB, with the larger-magnitude operand as minuend.
  - result_sign = sign of the larger operand; a zero result gives +0.
- Without the macro: signs do not exist, operation is always ADD, and the result sign is fixed 0.

Decomposition:
- Package fp_ctrl_pkg holds:
  - the state enum;
  - opcodes SMALL_SUB=4'b0001, BIG_ADD=4'b0000, BIG_SUB=4'b0001, INC=4'b0001, DEC=4'b0010, NOP=4'b0000;
  - the EXP_W/MAN_W defaults.
- Sub-module fp_lod: (MAN_W+2)-bit leading-one detector, outputs position and a zero flag.

Test Plan:
- exp_a=exp_b=127, big_sum=25'h1000000 (1.0+1.0) -> sel_small=1, shift_right_amt=0, NORM shift_norm_amt=-1 with INC, done at cycle 7, overflow=0.
- exp_a=130, exp_b=127 -> sel_small=1, sel_large=0, shift_right_amt=3. Swapped operands -> sel_small=0, shift_right_amt=3.
- exp_a=100, exp_b=150 -> shift_right_amt=25.
- not_normalized held 1 with MAX_RENORM=2 -> exactly two re-passes, then forced DONE with done at cycle 13. sel_mant_src=1 and sel_exp_src=1 during each re-pass.
- exp_a=exp_b=254 with big_sum bit 24 set -> overflow=1, held until next start.
- reset pulsed during ADD -> all outputs 0 immediately, no done. Next start gives a normal 7-cycle run.
- FP_CTRL_SUB_EN defined, sign_a=0, sign_b=1, equal exponents, big_sum=0 -> big_alu_op=BIG_SUB, result zero with result_sign=0, done asserted.

Source files
------------

// File: rtl/fp_ctrl_pkg.sv
// fp_ctrl_pkg: shared definitions for the floating-point add control FSM.
//   - Default exponent / fraction widths.
//   - FSM state encoding.
//   - Opcodes driven onto the small ALU, big ALU and exponent inc/dec unit.
package fp_ctrl_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXP_CMP = 3'd1,
    S_ALIGN   = 3'd2,
    S_ADD     = 3'd3,
    S_NORM    = 3'd4,
    S_ROUND   = 3'd5,
    S_CHECK   = 3'd6,
    S_DONE    = 3'd7
  } fp_state_e;

  localparam logic [3:0] NOP       = 4'b0000;
  localparam logic [3:0] SMALL_SUB = 4'b0001;
  localparam logic [3:0] BIG_ADD   = 4'b0000;
  localparam logic [3:0] BIG_SUB   = 4'b0001;
  localparam logic [3:0] INC       = 4'b0001;
  localparam logic [3:0] DEC       = 4'b0010;

endpackage

// File: rtl/fp_add_control_lod.sv
// fp_lod: leading-one detector for the mantissa sum.
// Ports:
//   vec  in  W   vector to scan
//   pos  out PW  index of the most significant set bit (0 when vec is zero)
//   zero out 1   vec is all zeros
module fp_lod
  import fp_ctrl_pkg::*;
#(
  parameter int W  = MAN_W_DEF + 2,
  parameter int PW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [PW-1:0] pos,
  output logic          zero
);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) pos = PW'(i);
    end
    zero = ~|vec;
  end

endmodule

// File: rtl/fp_add_control.sv
// fp_add_control: control FSM for the floating-point add datapath.
// Sequence: IDLE -> EXP_CMP -> ALIGN -> ADD -> NORM -> ROUND -> CHECK -> DONE,
// with CHECK able to loop back to NORM up to MAX_RENORM times.
// Optional build macro FP_CTRL_SUB_EN adds sign handling (effective subtract).
// Ports:
//   clk, reset (async, active-high)
//   start            begin an operation (sampled in IDLE only)
//   exp_a, exp_b     operand exponent fields
//   big_sum          mantissa on the normaliser input (carry at MAN_W+1)
//   not_normalized   rounder result still needs normalising
//   busy, done       handshake to the core
//   sel_*            datapath mux selects
//   shift_right_amt  alignment shift; shift_norm_amt signed normalise shift
//   small_alu_op, big_alu_op, incdec_op, incdec_en, load_final
//   overflow, underflow  sticky exponent range flags, cleared by start
//   sign_a, sign_b, result_sign  (FP_CTRL_SUB_EN only)
module fp_add_control
  import fp_ctrl_pkg::*;
#(
  parameter int EXP_W      = EXP_W_DEF,
  parameter int MAN_W      = MAN_W_DEF,
  parameter int MAX_RENORM = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [MAN_W+1:0]   big_sum,
  input  logic               not_normalized,
`ifdef FP_CTRL_SUB_EN
  input  logic               sign_a,
  input  logic               sign_b,
  output logic               result_sign,
`endif
  output logic               busy,
  output logic               done,
  output logic               sel_small,
  output logic               sel_large,
  output logic               sel_exp_src,
  output logic               sel_mant_src,
  output logic               sel_exp_out,
  output logic [7:0]         shift_right_amt,
  output logic signed [5:0]  shift_norm_amt,
  output logic [3:0]         small_alu_op,
  output logic [3:0]         big_alu_op,
  output logic [3:0]         incdec_op,
  output logic               incdec_en,
  output logic               load_final,
  output logic               overflow,
  output logic               underflow
);

  localparam int LW    = MAN_W + 2;
  localparam int PW    = $clog2(LW);
  localparam int CNT_W = $clog2(MAX_RENORM + 2);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RENORM);
  // Largest finite exponent: all ones except the LSB.
  localparam logic [EXP_W-1:0] EXP_SAT = {{(EXP_W-1){1'b1}}, 1'b0};

  fp_state_e        state_q, state_d;
  logic [EXP_W-1:0] diff_q, diff_d;
  logic [EXP_W-1:0] e_res_q, e_res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_small_q, sel_small_d;
  logic             sel_vld_q, sel_vld_d;
  logic             adj_q, adj_d;
  logic             repass_q, repass_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
`ifdef FP_CTRL_SUB_EN
  logic             eff_sub_q, eff_sub_d;
  logic             sign_q, sign_d;
`endif

  logic [PW-1:0]    lod_pos;
  logic             lod_zero;
  logic [5:0]       lz_cnt;
  logic             b_le_a;

  // On a re-pass the datapath routes the rounder feedback onto big_sum,
  // so the detector always looks at the same port.
  fp_lod #(.W(LW), .PW(PW)) u_lod (
    .vec  (big_sum),
    .pos  (lod_pos),
    .zero (lod_zero)
  );

  assign lz_cnt = 6'(MAN_W) - 6'(lod_pos);
  assign b_le_a = (exp_b <= exp_a);

  always_comb begin
    state_d         = state_q;
    diff_d          = diff_q;
    e_res_d         = e_res_q;
    cnt_d           = cnt_q;
    sel_small_d     = sel_small_q;
    sel_vld_d       = sel_vld_q;
    adj_d           = adj_q;
    repass_d        = repass_q;
    ovf_d           = ovf_q;
    unf_d           = unf_q;
`ifdef FP_CTRL_SUB_EN
    eff_sub_d       = eff_sub_q;
    sign_d          = sign_q;
`endif
    sel_exp_src     = 1'b0;
    sel_mant_src    = 1'b0;
    sel_exp_out     = 1'b0;
    shift_right_amt = '0;
    shift_norm_amt  = '0;
    small_alu_op    = NOP;
    big_alu_op      = NOP;
    incdec_op       = NOP;
    incdec_en       = 1'b0;
    load_final      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_EXP_CMP;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          cnt_d    = '0;
          repass_d = 1'b0;
          adj_d    = 1'b0;
        end
      end

      S_EXP_CMP: begin
        small_alu_op = SMALL_SUB;
        sel_small_d  = b_le_a;
        sel_vld_d    = 1'b1;
        diff_d       = b_le_a ? (exp_a - exp_b) : (exp_b - exp_a);
        e_res_d      = b_le_a ? exp_a : exp_b;
`ifdef FP_CTRL_SUB_EN
        eff_sub_d    = sign_a ^ sign_b;
        sign_d       = b_le_a ? sign_a : sign_b;
`endif
        state_d      = S_ALIGN;
      end

      S_ALIGN: begin
        // Beyond MAN_W+2 the shifted operand is already all zeros.
        if ({1'b0, diff_q} > (EXP_W+1)'(MAN_W + 2))
          shift_right_amt = 8'(MAN_W + 2);
        else
          shift_right_amt = 8'(diff_q);
        state_d = S_ADD;
      end

      S_ADD: begin
`ifdef FP_CTRL_SUB_EN
        big_alu_op = eff_sub_q ? BIG_SUB : BIG_ADD;
`else
        big_alu_op = BIG_ADD;
`endif
        state_d = S_NORM;
      end

      S_NORM: begin
        sel_mant_src = repass_q;
        sel_exp_src  = repass_q;
        if (big_sum[MAN_W+1]) begin
          shift_norm_amt = -6'sd1;
          incdec_op      = INC;
          incdec_en      = 1'b1;
          adj_d          = 1'b1;
          if (({1'b0, e_res_q} + (EXP_W+1)'(1)) >= {1'b0, {EXP_W{1'b1}}}) begin
            ovf_d   = 1'b1;
            e_res_d = EXP_SAT;
          end else begin
            e_res_d = e_res_q + EXP_W'(1);
          end
          state_d = S_ROUND;
        end else if (lod_zero) begin
          // Exact zero: nothing to round, load it and finish.
          e_res_d    = '0;
          load_final = 1'b1;
`ifdef FP_CTRL_SUB_EN
          sign_d     = 1'b0;
`endif
          state_d    = S_DONE;
        end else begin
          shift_norm_amt = signed'(lz_cnt);
          incdec_op      = DEC;
          incdec_en      = (lz_cnt != '0);
          adj_d          = (lz_cnt != '0);
          if ((lz_cnt != '0) && ({1'b0, e_res_q} <= (EXP_W+1)'(lz_cnt))) begin
            unf_d   = 1'b1;
            e_res_d = '0;
`ifdef FP_CTRL_SUB_EN
            sign_d  = 1'b0;
`endif
          end else begin
            e_res_d = e_res_q - EXP_W'(lz_cnt);
          end
          state_d = S_ROUND;
        end
      end

      S_ROUND: begin
        load_final  = 1'b1;
        // Unadjusted exponent comes straight from the small-ALU register.
        sel_exp_out = ~adj_q;
        state_d     = S_CHECK;
      end

      S_CHECK: begin
        if (not_normalized && (cnt_q < MAX_CNT)) begin
          cnt_d    = cnt_q + CNT_W'(1);
          repass_d = 1'b1;
          state_d  = S_NORM;
        end else begin
          state_d  = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      diff_q      <= '0;
      e_res_q     <= '0;
      cnt_q       <= '0;
      sel_small_q <= 1'b0;
      sel_vld_q   <= 1'b0;
      adj_q       <= 1'b0;
      repass_q    <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
`ifdef FP_CTRL_SUB_EN
      eff_sub_q   <= 1'b0;
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      diff_q      <= diff_d;
      e_res_q     <= e_res_d;
      cnt_q       <= cnt_d;
      sel_small_q <= sel_small_d;
      sel_vld_q   <= sel_vld_d;
      adj_q       <= adj_d;
      repass_q    <= repass_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
`ifdef FP_CTRL_SUB_EN
      eff_sub_q   <= eff_sub_d;
      sign_q      <= sign_d;
`endif
    end
  end

  // Selects follow the live compare in EXP_CMP and hold afterwards; both
  // read 0 until the first compare after reset.
  assign sel_small = (state_q == S_EXP_CMP) ? b_le_a : sel_small_q;
  assign sel_large = (state_q == S_EXP_CMP) ? ~b_le_a : (sel_vld_q & ~sel_small_q);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign overflow  = ovf_q;
  assign underflow = unf_q;
`ifdef FP_CTRL_SUB_EN
  assign result_sign = sign_q;
`endif

endmodule

// File: tb/tb_fp_add_control.sv
module tb_fp_add_control;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        exp_a, exp_b;
  logic [24:0]       big_sum;
  logic              not_normalized;
`ifdef FP_CTRL_SUB_EN
  logic              sign_a, sign_b, result_sign;
`endif
  logic              busy, done, sel_small, sel_large, sel_exp_src, sel_mant_src, sel_exp_out;
  logic [7:0]        shift_right_amt;
  logic signed [5:0] shift_norm_amt;
  logic [3:0]        small_alu_op, big_alu_op, incdec_op;
  logic              incdec_en, load_final, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  fp_add_control #(.EXP_W(8), .MAN_W(23), .MAX_RENORM(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .exp_a           (exp_a),
    .exp_b           (exp_b),
    .big_sum         (big_sum),
    .not_normalized  (not_normalized),
`ifdef FP_CTRL_SUB_EN
    .sign_a          (sign_a),
    .sign_b          (sign_b),
    .result_sign     (result_sign),
`endif
    .busy            (busy),
    .done            (done),
    .sel_small       (sel_small),
    .sel_large       (sel_large),
    .sel_exp_src     (sel_exp_src),
    .sel_mant_src    (sel_mant_src),
    .sel_exp_out     (sel_exp_out),
    .shift_right_amt (shift_right_amt),
    .shift_norm_amt  (shift_norm_amt),
    .small_alu_op    (small_alu_op),
    .big_alu_op      (big_alu_op),
    .incdec_op       (incdec_op),
    .incdec_en       (incdec_en),
    .load_final      (load_final),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start for one edge; returns positioned in cycle 1 (EXP_CMP).
  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic [24:0] s);
    exp_a   = a;
    exp_b   = b;
    big_sum = s;
    start   = 1'b1;
    step(1);
    start   = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int k;
    k = 0;
    while (busy && k < 30) begin
      step(1);
      k++;
    end
    timed_out = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    exp_a = '0; exp_b = '0; big_sum = '0; not_normalized = 1'b0;
`ifdef FP_CTRL_SUB_EN
    sign_a = 1'b0; sign_b = 1'b0;
`endif
    #12;
    n_tests++;
    if ({busy, done, overflow, underflow} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, overflow, underflow});
    end
    n_tests++;
    if ({sel_small, sel_large, sel_exp_src, sel_mant_src, sel_exp_out, incdec_en, load_final} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_sels: got %b want 0000000",
               {sel_small, sel_large, sel_exp_src, sel_mant_src, sel_exp_out, incdec_en, load_final});
    end
    n_tests++;
    if ({small_alu_op, big_alu_op, incdec_op, shift_right_amt, shift_norm_amt} !== 26'b0) begin
      n_fail++;
      $display("FAIL reset_ops: got %h want 0",
               {small_alu_op, big_alu_op, incdec_op, shift_right_amt, shift_norm_amt});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_one_plus_one;
    bit to;
    not_normalized = 1'b0;
    do_start(8'd127, 8'd127, 25'h1000000);
    n_tests++;
    if (small_alu_op !== 4'd1 || sel_small !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL expcmp_1p1: op=%0d sel_small=%b busy=%b want 1 1 1", small_alu_op, sel_small, busy);
    end
    step(1);
    n_tests++;
    if (shift_right_amt !== 8'd0) begin
      n_fail++;
      $display("FAIL align_tie: got %0d want 0", shift_right_amt);
    end
    step(2);
    n_tests++;
    if (shift_norm_amt !== -6'sd1 || incdec_op !== 4'd1 || incdec_en !== 1'b1) begin
      n_fail++;
      $display("FAIL norm_carry: shift=%0d op=%0d en=%b want -1 1 1", shift_norm_amt, incdec_op, incdec_en);
    end
    step(1);
    n_tests++;
    if (load_final !== 1'b1 || sel_exp_out !== 1'b0) begin
      n_fail++;
      $display("FAIL round_1p1: load=%b sel_exp_out=%b want 1 0", load_final, sel_exp_out);
    end
    step(1);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_early: got %b at cycle 6 want 0", done);
    end
    step(1);
    n_tests++;
    if (done !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL done_c7: done=%b ovf=%b want 1 0", done, overflow);
    end
    wait_idle(to);
    n_tests++;
    if (to || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after: busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_align;
    bit to;
    not_normalized = 1'b0;
    do_start(8'd130, 8'd127, 25'h0200000);
    step(1);
    n_tests++;
    if (sel_small !== 1'b1 || sel_large !== 1'b0 || shift_right_amt !== 8'd3) begin
      n_fail++;
      $display("FAIL align_a_big: small=%b large=%b amt=%0d want 1 0 3", sel_small, sel_large, shift_right_amt);
    end
    step(2);
    n_tests++;
    if (shift_norm_amt !== 6'sd2 || incdec_op !== 4'd2 || incdec_en !== 1'b1) begin
      n_fail++;
      $display("FAIL norm_left2: shift=%0d op=%0d en=%b want 2 2 1", shift_norm_amt, incdec_op, incdec_en);
    end
    wait_idle(to);

    do_start(8'd127, 8'd130, 25'h0800000);
    step(1);
    n_tests++;
    if (sel_small !== 1'b0 || sel_large !== 1'b1 || shift_right_amt !== 8'd3) begin
      n_fail++;
      $display("FAIL align_b_big: small=%b large=%b amt=%0d want 0 1 3", sel_small, sel_large, shift_right_amt);
    end
    step(2);
    n_tests++;
    if (shift_norm_amt !== 6'sd0 || incdec_en !== 1'b0) begin
      n_fail++;
      $display("FAIL norm_noadj: shift=%0d en=%b want 0 0", shift_norm_amt, incdec_en);
    end
    step(1);
    n_tests++;
    if (sel_exp_out !== 1'b1 || load_final !== 1'b1) begin
      n_fail++;
      $display("FAIL round_noadj: sel_exp_out=%b load=%b want 1 1", sel_exp_out, load_final);
    end
    wait_idle(to);

    do_start(8'd100, 8'd150, 25'h0800000);
    step(1);
    n_tests++;
    if (shift_right_amt !== 8'd25) begin
      n_fail++;
      $display("FAIL align_clamp: got %0d want 25", shift_right_amt);
    end
    wait_idle(to);
    n_tests++;
    if (to) begin
      n_fail++;
      $display("FAIL align_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_renorm;
    bit to;
    not_normalized = 1'b1;
    do_start(8'd127, 8'd127, 25'h0800000);
    step(3);
    n_tests++;
    if (incdec_op !== 4'd2 || sel_mant_src !== 1'b0 || sel_exp_src !== 1'b0) begin
      n_fail++;
      $display("FAIL renorm_first: op=%0d mant=%b exp=%b want 2 0 0", incdec_op, sel_mant_src, sel_exp_src);
    end
    step(3);
    n_tests++;
    if (incdec_op !== 4'd2 || sel_mant_src !== 1'b1 || sel_exp_src !== 1'b1) begin
      n_fail++;
      $display("FAIL renorm_pass1: op=%0d mant=%b exp=%b want 2 1 1", incdec_op, sel_mant_src, sel_exp_src);
    end
    step(3);
    n_tests++;
    if (incdec_op !== 4'd2 || sel_mant_src !== 1'b1 || sel_exp_src !== 1'b1) begin
      n_fail++;
      $display("FAIL renorm_pass2: op=%0d mant=%b exp=%b want 2 1 1", incdec_op, sel_mant_src, sel_exp_src);
    end
    step(2);
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL renorm_c12: done=%b want 0", done);
    end
    step(1);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL renorm_c13: done=%b want 1", done);
    end
    not_normalized = 1'b0;
    wait_idle(to);
  endtask

  task automatic test_exp_bounds;
    bit to;
    not_normalized = 1'b0;
    do_start(8'd254, 8'd254, 25'h1000000);
    step(4);
    n_tests++;
    if (overflow !== 1'b1 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_set: ovf=%b unf=%b want 1 0", overflow, underflow);
    end
    wait_idle(to);
    step(2);
    n_tests++;
    if (overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
    do_start(8'd1, 8'd1, 25'h0200000);
    n_tests++;
    if (overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_clear: got %b want 0", overflow);
    end
    step(4);
    n_tests++;
    if (underflow !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_set: unf=%b ovf=%b want 1 0", underflow, overflow);
    end
    wait_idle(to);
  endtask

  task automatic test_reset_mid;
    int  cyc;
    bit  seen_done;
    not_normalized = 1'b0;
    do_start(8'd127, 8'd127, 25'h1000000);
    step(2);
    reset = 1'b1;
    #1;
    n_tests++;
    if (busy !== 1'b0 || sel_small !== 1'b0 || done !== 1'b0 || load_final !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b small=%b done=%b load=%b want 0 0 0 0",
               busy, sel_small, done, load_final);
    end
    step(2);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (done) seen_done = 1'b1;
    end
    n_tests++;
    if (seen_done) begin
      n_fail++;
      $display("FAIL reset_no_done: saw done=1 want none");
    end
    do_start(8'd127, 8'd127, 25'h1000000);
    cyc = 1;
    while (!done && cyc < 30) begin
      step(1);
      cyc++;
    end
    n_tests++;
    if (cyc !== 7) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d want 7", cyc);
    end
    step(1);
  endtask

`ifdef FP_CTRL_SUB_EN
  task automatic test_sub;
    bit to;
    sign_a = 1'b0;
    sign_b = 1'b1;
    not_normalized = 1'b0;
    do_start(8'd127, 8'd127, 25'h0000000);
    step(2);
    n_tests++;
    if (big_alu_op !== 4'd1) begin
      n_fail++;
      $display("FAIL sub_op: got %0d want 1", big_alu_op);
    end
    step(1);
    n_tests++;
    if (load_final !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_zero_load: got %b want 1", load_final);
    end
    step(1);
    n_tests++;
    if (done !== 1'b1 || result_sign !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_zero_done: done=%b sign=%b want 1 0", done, result_sign);
    end
    wait_idle(to);
    sign_b = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_one_plus_one();
    test_align();
    test_renorm();
    test_exp_bounds();
    test_reset_mid();
`ifdef FP_CTRL_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
